// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluation core: opcodes, fault codes, FSM states.
package rpn_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_POP  = 4'd4;
  localparam logic [3:0] OP_DUP  = 4'd5;
  localparam logic [3:0] OP_SWAP = 4'd6;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_DIVZ  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_WB  = 2'd2
  } state_e;

  // Number of stack entries an opcode consumes before it can execute.
  function automatic logic [1:0] op_operands(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SWAP: return 2'd2;
      OP_POP, OP_DUP:                          return 2'd1;
      default:                                 return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rpn_stack_core_if.sv
// Command port of the RPN core: valid/ready handshake carrying a push literal or opcode.
interface rpn_stack_core_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_is_op;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_is_op, cmd_op, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_is_op, cmd_op, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/rpn_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles after start.
// done_c is high during the cycle whose clock edge completes the final iteration.
module rpn_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_c,
  output logic [WIDTH-1:0] quotient
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   rem_t;
  logic [WIDTH:0]   diff;

  // Load operands on start, otherwise shift-subtract one bit while running.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rem_t = {rem_q, quo_q[WIDTH-1]};
    diff  = rem_t - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_t[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      run_d = (cnt_q != CW'(1));
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_c   = run_q && (cnt_q == CW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/rpn_stack_core.sv
// RPN evaluation core: operand stack, four-function ALU and optional iterative divider.
// Optional feature macro: RPN_DIV_EN (divider and DIV_RUN/DIV_WB states; otherwise DIV is unknown).
module rpn_stack_core
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  rpn_stack_core_if.slave            cmd,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       err_valid,
  output logic [1:0]                 err_code
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [IW-1:0]    tos_idx_c, nos_idx_c, push_idx_c;
  logic [WIDTH-1:0] tos_c, nos_c;
  logic             fire_c, full_c, under_c, unknown_c;

  // Stack pointer arithmetic; TOS/NOS are read straight from the register array.
  assign tos_idx_c  = IW'(depth_q - DW'(1));
  assign nos_idx_c  = IW'(depth_q - DW'(2));
  assign push_idx_c = IW'(depth_q);
  assign tos_c      = stk_q[tos_idx_c];
  assign nos_c      = stk_q[nos_idx_c];
  assign full_c     = (depth_q == DW'(DEPTH));
  assign under_c    = (depth_q < DW'(op_operands(cmd.cmd_op)));
  assign fire_c     = cmd.cmd_valid & cmd.cmd_ready;

`ifdef RPN_DIV_EN
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             div_go_c, div_done_c;
  logic [WIDTH-1:0] div_quo;

  assign unknown_c     = (cmd.cmd_op > OP_SWAP);
  assign div_go_c      = fire_c && cmd.cmd_is_op && (cmd.cmd_op == OP_DIV) &&
                         !under_c && (tos_c != '0);
  assign cmd.cmd_ready = !busy_q;
  assign busy          = busy_q;

  rpn_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_go_c),
    .dividend (nos_c),
    .divisor  (tos_c),
    .done_c   (div_done_c),
    .quotient (div_quo)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a valid DIV launches the divider, its last iteration leads to writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (div_go_c) state_d = S_DIV_RUN;
      S_DIV_RUN: if (div_done_c) state_d = S_DIV_WB;
      S_DIV_WB:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM output: busy covers DIV_RUN and DIV_WB.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  // Busy flag register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= busy_d;
  end
`else
  assign unknown_c     = (cmd.cmd_op > OP_SWAP) || (cmd.cmd_op == OP_DIV);
  assign cmd.cmd_ready = 1'b1;
  assign busy          = 1'b0;
`endif

  // Stack update and fault reporting for the accepted command or divide writeback.
  always_comb begin
    stk_d       = stk_q;
    depth_d     = depth_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    if (fire_c) begin
      if (!cmd.cmd_is_op) begin
        if (full_c) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_OVER;
        end else begin
          stk_d[push_idx_c] = cmd.cmd_data;
          depth_d           = depth_q + DW'(1);
        end
      end else if (unknown_c) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_DIVZ;
      end else if (under_c) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_UNDER;
      end else begin
        case (cmd.cmd_op)
          OP_ADD: begin
            stk_d[nos_idx_c] = nos_c + tos_c;
            depth_d          = depth_q - DW'(1);
          end
          OP_SUB: begin
            stk_d[nos_idx_c] = nos_c - tos_c;
            depth_d          = depth_q - DW'(1);
          end
          OP_MUL: begin
            stk_d[nos_idx_c] = nos_c * tos_c;
            depth_d          = depth_q - DW'(1);
          end
          OP_DIV: begin
            // Non-zero divisors are handed to the divider; zero resolves here.
            if (tos_c == '0) begin
              stk_d[nos_idx_c] = '1;
              depth_d          = depth_q - DW'(1);
              err_valid_d      = 1'b1;
              err_code_d       = ERR_DIVZ;
            end
          end
          OP_POP: begin
            depth_d = depth_q - DW'(1);
          end
          OP_DUP: begin
            if (full_c) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_OVER;
            end else begin
              stk_d[push_idx_c] = tos_c;
              depth_d           = depth_q + DW'(1);
            end
          end
          OP_SWAP: begin
            stk_d[nos_idx_c] = tos_c;
            stk_d[tos_idx_c] = nos_c;
          end
          default: ;
        endcase
      end
    end
`ifdef RPN_DIV_EN
    if (state_q == S_DIV_WB) begin
      stk_d[nos_idx_c] = div_quo;
      depth_d          = depth_q - DW'(1);
    end
`endif
  end

  // Pointer and fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      depth_q     <= depth_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  // Stack storage; contents are only meaningful below the pointer.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign top       = (depth_q == '0) ? '0 : tos_c;
  assign depth     = depth_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_rpn_stack_core.sv
// Directed bench for rpn_stack_core; expectations follow RPN_DIV_EN when it is defined.
module tb_rpn_stack_core;
  import rpn_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] top;
  logic [3:0]       depth;
  logic             busy;
  logic             err_valid;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpn_stack_core_if #(.WIDTH(WIDTH)) cmd_if ();

  rpn_stack_core #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .top       (top),
    .depth     (depth),
    .busy      (busy),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_top,
                             input logic [31:0] e_depth, input logic [31:0] e_ev,
                             input logic [31:0] e_code);
    check({tag, "_top"}, 32'(top), e_top);
    check({tag, "_depth"}, 32'(depth), e_depth);
    check({tag, "_err_valid"}, 32'(err_valid), e_ev);
    check({tag, "_err_code"}, 32'(err_code), e_code);
  endtask

  task automatic do_reset();
    cmd_if.cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic is_op, input logic [3:0] op, input logic [WIDTH-1:0] data);
    int n;
    n = 0;
    while (!cmd_if.cmd_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_is_op = is_op;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_is_op = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    send(1'b0, 4'd0, d);
  endtask

  task automatic exec(input logic [3:0] op);
    send(1'b1, op, '0);
  endtask

  // Counts busy cycles after a DIV and notes whether ready was ever high meanwhile.
  task automatic wait_div(output int cycles, output int ready_seen);
    cycles = 0;
    ready_seen = 0;
    while (busy && cycles < 60) begin
      if (cmd_if.cmd_ready) ready_seen++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    int rdy;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_is_op = 1'b0;
    cmd_if.cmd_op    = 4'd0;
    cmd_if.cmd_data  = '0;

    // Reset values
    do_reset();
    check_state("reset", 32'h0, 32'd0, 32'd0, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Subtraction order and wraparound
    push(16'd7);
    push(16'd3);
    exec(OP_SUB);
    check_state("sub", 32'd4, 32'd1, 32'd0, 32'd0);
    push(16'd5);
    exec(OP_SUB);
    check_state("sub_wrap", 32'hFFFF, 32'd1, 32'd0, 32'd0);

    // Multiply keeps low bits; add wraps
    exec(OP_POP);
    check_state("pop_empty", 32'h0, 32'd0, 32'd0, 32'd0);
    push(16'd300);
    push(16'd300);
    exec(OP_MUL);
    check_state("mul", 32'h5F90, 32'd1, 32'd0, 32'd0);
    push(16'hFFF0);
    exec(OP_ADD);
    check_state("add_wrap", 32'h5F80, 32'd1, 32'd0, 32'd0);

    // Divide with a non-zero divisor
    do_reset();
    push(16'd100);
    push(16'd7);
    exec(OP_DIV);
`ifdef RPN_DIV_EN
    check("div_busy_rise", 32'(busy), 32'd1);
    check("div_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    wait_div(cyc, rdy);
    check("div_busy_cycles", 32'(cyc), 32'd17);
    check("div_ready_during_busy", 32'(rdy), 32'd0);
    check_state("div", 32'd14, 32'd1, 32'd0, 32'd0);
`else
    check("div_busy", 32'(busy), 32'd0);
    check_state("div_unknown", 32'd7, 32'd2, 32'd1, 32'd3);
`endif

    // Divide by zero, held code, then underflow
    do_reset();
    push(16'd5);
    push(16'd0);
    exec(OP_DIV);
`ifdef RPN_DIV_EN
    check_state("div0", 32'hFFFF, 32'd1, 32'd1, 32'd3);
`else
    check_state("div0_unknown", 32'h0, 32'd2, 32'd1, 32'd3);
`endif
    check("div0_busy", 32'(busy), 32'd0);
    push(16'd1);
    check("err_pulse_end", 32'(err_valid), 32'd0);
    check("err_code_held", 32'(err_code), 32'd3);
    do_reset();
    push(16'd9);
    exec(OP_ADD);
    check_state("add_under", 32'd9, 32'd1, 32'd1, 32'd1);
    exec(OP_POP);
    exec(OP_POP);
    check_state("pop_under", 32'h0, 32'd0, 32'd1, 32'd1);
    push(16'd42);
    exec(OP_DUP);
    check_state("dup", 32'd42, 32'd2, 32'd0, 32'd1);

    // Full stack: push/DUP overflow, SWAP and unknown opcode
    do_reset();
    for (int i = 1; i <= int'(DEPTH); i++) push(16'(i * 11));
    check_state("fill", 32'd88, 32'd8, 32'd0, 32'd0);
    push(16'd1);
    check_state("push_over", 32'd88, 32'd8, 32'd1, 32'd2);
    exec(OP_DUP);
    check_state("dup_over", 32'd88, 32'd8, 32'd1, 32'd2);
    exec(OP_SWAP);
    check_state("swap", 32'd77, 32'd8, 32'd0, 32'd2);
    exec(4'hF);
    check_state("unknown_op", 32'd77, 32'd8, 32'd1, 32'd3);
    exec(OP_POP);
    check_state("pop_after_swap", 32'd88, 32'd7, 32'd0, 32'd3);

    // Reset in the middle of a divide
    do_reset();
    push(16'd100);
    push(16'd7);
    exec(OP_DIV);
`ifdef RPN_DIV_EN
    repeat (5) @(posedge clk);
    #1;
    check("mid_div_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("div_abort", 32'h0, 32'd0, 32'd0, 32'd0);
    check("div_abort_busy", 32'(busy), 32'd0);
    check("div_abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
    rst = 1'b0;
    push(16'd20);
    push(16'd6);
    exec(OP_DIV);
    wait_div(cyc, rdy);
    check("div2_busy_cycles", 32'(cyc), 32'd17);
    check_state("div2", 32'd3, 32'd1, 32'd0, 32'd0);
`else
    check_state("div_nodiv", 32'd7, 32'd2, 32'd1, 32'd3);
    check("div_nodiv_busy", 32'(busy), 32'd0);
    check("div_nodiv_ready", 32'(cmd_if.cmd_ready), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_stack_core.md
# rpn_stack_core

Parametrised RPN evaluation core: an operand stack, the four-function arithmetic unit and a multi-cycle divider behind one valid/ready command port. It sits between the UART command decoder and the result formatter, replacing the purely combinational two-operand ALU stage. Numbers are pushed, operators consume operands from the stack top, and results are pushed back, with explicit error reporting.

## Interface
- `WIDTH`, 16: operand/result width in bits (≥4).
- `DEPTH`, 8: stack capacity in entries (≥2).
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: core accepts command this cycle.
- `cmd_is_op`  in  1: 0 = push `cmd_data`, 1 = execute `cmd_op`.
- `cmd_op`  in  4: opcode: ADD 0, SUB 1, MUL 2, DIV 3, POP 4, DUP 5, SWAP 6; all others unknown.
- `cmd_data`  in  WIDTH: literal for push.
- `top`  out  WIDTH: current top of stack (TOS); 0 when empty.
- `depth`  out  $clog2(DEPTH+1): occupied entries.
- `busy`  out  1: divide in progress.
- `err_valid`  out  1: one-cycle pulse, the last accepted command faulted.
- `err_code`  out  2: 1 underflow, 2 overflow, 3 divide-by-zero/unknown op; held until the next fault.

## Operation
- Handshake: transfer on `cmd_valid & cmd_ready`; `cmd_ready = !busy`.
- left = next-on-stack (NOS), right = TOS. Binary ops pop 2 and push 1; POP pops 1; DUP pushes a copy of TOS; SWAP exchanges TOS/NOS.
- Required operand counts: ADD/SUB/MUL/DIV/SWAP 2, POP/DUP 1. If `depth` is below the count: underflow fault, stack unchanged.
- Push with `depth == DEPTH`, or DUP at full: overflow fault, stack unchanged.
- Unknown opcode: code 3, stack unchanged.
- Arithmetic: unsigned, modulo 2^WIDTH; SUB wraps; MUL keeps the low WIDTH bits; DIV truncates.
- DIV by 0: pops both operands, pushes all-ones, code 3 fault.
- FSM states:
  - IDLE: all commands accepted; DIV with valid operands goes to DIV_RUN.
  - DIV_RUN: WIDTH restoring-division iterations, one per cycle; goes to DIV_WB.
  - DIV_WB: writes the quotient, returns to IDLE.
- Divide-by-zero is resolved in IDLE; the FSM does not enter DIV_RUN.

## Timing
- Reset: stack empty; `depth = 0`; `top = 0`; `busy = 0`; `err_valid = 0`; `err_code = 0`; FSM in IDLE; `cmd_ready = 1` in the first cycle after reset.
- Non-DIV commands: single cycle. `top`, `depth` and `err_*` reflect the command in the cycle after acceptance. Back-to-back acceptance every cycle is supported.
- DIV: `busy` rises the cycle after acceptance and stays high WIDTH+1 cycles (DIV_RUN + DIV_WB). The result appears on `top` the cycle `busy` falls. Total latency is WIDTH+2 cycles from acceptance to result.
- `rst` asserted mid-divide aborts the operation; the next cycle shows reset values.
- `err_valid` pulses exactly one cycle, coincident with the faulting command's state update.

## Configuration
- `RPN_DIV_EN`
  - Defined: divider and DIV_RUN/DIV_WB states present, behaviour as above.
  - Undefined: DIV is treated as an unknown opcode (code 3, stack unchanged, no `busy`); `busy` is tied to 0.

## Structure
- Shared package `rpn_pkg`: opcode constants, `err_code` encodings, FSM state enum, operand-count function.
- Sub-module `rpn_divider`: iterative restoring divider with a start/done interface. Parametrised by WIDTH; instantiated only under `RPN_DIV_EN`.
- Stack is a register array plus pointer, so TOS and NOS are readable combinationally.

## Test plan
- Push 7, push 3, SUB → `top = 4`, `depth = 1`; then push 5, SUB → `top = 0xFFFF` (wrap).
- Push 300, push 300, MUL → `top = 0x5F90` (low 16 bits of 90000), no fault.
- Push 100, push 7, DIV → `busy` high for 17 cycles, `cmd_ready` low during that time, then `top = 14`, `depth = 1`.
- Push 5, push 0, DIV → `top = 0xFFFF`, `err_valid` pulse, `err_code = 3`, `depth = 1`; ADD on a single entry → `err_code = 1`, stack unchanged.
- Push DEPTH values, then push 1 → `err_code = 2`, `depth = DEPTH`, `top` unchanged; DUP at full → same result.
- `rst` asserted 5 cycles into a DIV → next cycle `depth = 0`, `busy = 0`, `cmd_ready = 1`; build without `RPN_DIV_EN`, DIV → immediate code 3.
